// File: rtl/cpu_clock_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_clock_ctrl_if
//   Groups the board-facing signals of the run/step clock controller.
//
//   Signals:
//     btn_run_n   raw RUN button, active-low, asynchronous
//     btn_step_n  raw STEP button, active-low, asynchronous
//     done        processor pass flag, launched in the cpu_clk domain
//     cpu_clk     divided processor clock, idles low
//     cpu_reset   processor reset, active-high
//     cycle_count cpu_clk rising edges since the last CLEAR
//     running     high while free-running
//     halted      high while halted
//     led_n       active-low LED, follows cpu_clk inverted
//     timeout     watchdog fired (constant low without CPU_CLK_WATCHDOG_EN)
//
//   Modports:
//     master  board / processor side (drives buttons and done)
//     slave   the clock controller itself
// -----------------------------------------------------------------------------
interface cpu_clock_ctrl_if #(
  parameter int CYC_W = 32
);
  logic             btn_run_n;
  logic             btn_step_n;
  logic             done;
  logic             cpu_clk;
  logic             cpu_reset;
  logic [CYC_W-1:0] cycle_count;
  logic             running;
  logic             halted;
  logic             led_n;
  logic             timeout;

  modport master (
    output btn_run_n, btn_step_n, done,
    input  cpu_clk, cpu_reset, cycle_count, running, halted, led_n, timeout
  );

  modport slave (
    input  btn_run_n, btn_step_n, done,
    output cpu_clk, cpu_reset, cycle_count, running, halted, led_n, timeout
  );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clock_ctrl
//   Run/step clock controller for the single-cycle processor. Conditions the
//   RUN and STEP push-buttons, divides clk into cpu_clk and sequences the
//   processor reset, free-run, single-step and auto-halt on the pass flag.
//
//   Ports:
//     clk    board clock; every register is clocked on its rising edge
//     reset  asynchronous, active-high; forces all outputs to idle values
//     bus    cpu_clock_ctrl_if.slave (buttons, done, cpu_clk, cpu_reset,
//            cycle_count, running, halted, led_n, timeout)
//
//   Parameters:
//     DIV_W       each cpu_clk half-period lasts 2^DIV_W clk cycles
//     DB_W        a button level must hold 2^DB_W clk cycles to be accepted
//     CYC_W       width of cycle_count
//     MAX_CYCLES  watchdog limit in cpu_clk rising edges
//
//   Optional build macro:
//     CPU_CLK_WATCHDOG_EN  when defined, a run or step that reaches
//                          MAX_CYCLES rising edges without done halts with
//                          timeout=1. When undefined, timeout is constant 0.
// -----------------------------------------------------------------------------
module cpu_clock_ctrl #(
  parameter int DIV_W      = 21,
  parameter int DB_W       = 16,
  parameter int CYC_W      = 32,
  parameter int MAX_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  cpu_clock_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, PAUSE, RUN, STEP, HALT} state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning: index 0 = RUN, index 1 = STEP.
  // The synchronizer and debounced level reset to "released" so that leaving
  // reset can never look like a press.
  // ---------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {bus.btn_step_n, bus.btn_run_n};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic [1:0]      sync_q;
    logic [DB_W-1:0] cnt_q;
    logic            level_q;
    logic            press_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q  <= 2'b11;
        cnt_q   <= '0;
        level_q <= 1'b1;
        press_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], btn_raw[gi]};
        press_q <= 1'b0;
        if (sync_q[1] == level_q) begin
          cnt_q <= '0;
        end else if (&cnt_q) begin
          // 2^DB_W consecutive samples disagreed with the accepted level.
          cnt_q   <= '0;
          level_q <= sync_q[1];
          press_q <= ~sync_q[1];
        end else begin
          cnt_q <= cnt_q + DB_W'(1);
        end
      end
    end

    assign press[gi] = press_q;
  end

  logic run_press;
  logic step_press;

  assign run_press  = press[0];
  assign step_press = press[1];

  // done is launched from the cpu_clk domain, which is unrelated in phase.
  logic [1:0] done_sync_q;
  logic       done_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) done_sync_q <= 2'b00;
    else       done_sync_q <= {done_sync_q[0], bus.done};
  end

  assign done_s = done_sync_q[1];

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic [DIV_W-1:0] presc_q;
  logic             cpu_clk_q;
  logic             cpu_reset_q;
  logic [CYC_W-1:0] cycle_q;
  logic             running_q;
  logic             halted_q;
  logic             led_n_q;
  logic             pend_q;       // run/step press seen in RUN, not yet serviced
  logic             step_fell_q;  // STEP has finished its high half-period
  logic             tick;
  logic             wd_hit;
  logic             period_end;

  // The prescaler only advances in CLEAR/RUN/STEP and is zeroed on every
  // state entry, so all-ones can only be reached in those states.
  assign tick = &presc_q;

  // End of a complete cpu_clk period, where done_s and the watchdog are judged.
  assign period_end = tick && (((state_q == RUN)  && cpu_clk_q) ||
                               ((state_q == STEP) && !cpu_clk_q && step_fell_q));

`ifdef CPU_CLK_WATCHDOG_EN
  logic timeout_q;

  assign wd_hit = (cycle_q == CYC_W'(MAX_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else if (run_press && ((state_q == IDLE) || (state_q == HALT))) begin
      timeout_q <= 1'b0;
    end else if (period_end && !done_s && wd_hit) begin
      timeout_q <= 1'b1;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign wd_hit      = 1'b0;
  // No watchdog: the limit is never negative, so this is constant low.
  assign bus.timeout = (MAX_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      cpu_clk_q   <= 1'b0;
      cpu_reset_q <= 1'b1;
      cycle_q     <= '0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      led_n_q     <= 1'b1;
      pend_q      <= 1'b0;
      step_fell_q <= 1'b0;
    end else begin
      if ((state_q == CLEAR) || (state_q == RUN) || (state_q == STEP)) begin
        presc_q <= presc_q + DIV_W'(1);
      end

      unique case (state_q)
        IDLE: begin
          if (run_press) begin
            state_q     <= CLEAR;
            presc_q     <= '0;
            cycle_q     <= '0;
            cpu_reset_q <= 1'b1;
          end
        end

        CLEAR: begin
          if (tick) begin
            state_q     <= PAUSE;
            presc_q     <= '0;
            cpu_reset_q <= 1'b0;
          end
        end

        PAUSE: begin
          // Run has priority over a simultaneous step.
          if (run_press) begin
            state_q   <= RUN;
            presc_q   <= '0;
            running_q <= 1'b1;
            pend_q    <= 1'b0;
          end else if (step_press) begin
            state_q     <= STEP;
            presc_q     <= '0;
            step_fell_q <= 1'b0;
          end
        end

        RUN: begin
          if (run_press || step_press) pend_q <= 1'b1;
          if (tick) begin
            cpu_clk_q <= ~cpu_clk_q;
            led_n_q   <= cpu_clk_q;
            if (!cpu_clk_q) begin
              cycle_q <= cycle_q + CYC_W'(1);
            end else if (done_s || wd_hit) begin
              state_q   <= HALT;
              presc_q   <= '0;
              running_q <= 1'b0;
              halted_q  <= 1'b1;
            end else if (pend_q || run_press || step_press) begin
              // Leave only on a falling tick so no period is ever cut short.
              state_q   <= PAUSE;
              presc_q   <= '0;
              running_q <= 1'b0;
            end
          end
        end

        STEP: begin
          if (tick) begin
            if (!cpu_clk_q && !step_fell_q) begin
              cpu_clk_q <= 1'b1;
              led_n_q   <= 1'b0;
              cycle_q   <= cycle_q + CYC_W'(1);
            end else if (cpu_clk_q) begin
              cpu_clk_q   <= 1'b0;
              led_n_q     <= 1'b1;
              step_fell_q <= 1'b1;
            end else begin
              // Trailing low half-period complete.
              presc_q <= '0;
              if (done_s || wd_hit) begin
                state_q  <= HALT;
                halted_q <= 1'b1;
              end else begin
                state_q <= PAUSE;
              end
            end
          end
        end

        HALT: begin
          if (run_press) begin
            state_q     <= CLEAR;
            presc_q     <= '0;
            cycle_q     <= '0;
            cpu_reset_q <= 1'b1;
            halted_q    <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_clk     = cpu_clk_q;
  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.cycle_count = cycle_q;
  assign bus.running     = running_q;
  assign bus.halted      = halted_q;
  assign bus.led_n       = led_n_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_clock_ctrl
//   Directed bench for cpu_clock_ctrl with DIV_W=2, DB_W=2. Expected values are
//   queued on a scoreboard as each step is driven and popped when the
//   corresponding DUT output is sampled. A negedge monitor checks the width of
//   every cpu_clk high pulse. With CPU_CLK_WATCHDOG_EN defined, an extra
//   watchdog scenario is run.
// -----------------------------------------------------------------------------
module tb_cpu_clock_ctrl;

  localparam int DIV_W  = 2;
  localparam int DB_W   = 2;
  localparam int CYC_W  = 32;
  localparam int TB_MAX = 1000;
  localparam int HALF   = 1 << DIV_W;

  logic clk;
  logic reset;

  cpu_clock_ctrl_if #(.CYC_W(CYC_W)) bus ();

  cpu_clock_ctrl #(
    .DIV_W      (DIV_W),
    .DB_W       (DB_W),
    .CYC_W      (CYC_W),
    .MAX_CYCLES (TB_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int hi_len   = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];

  task automatic expect_v(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic check_v(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_underflow observed=%0d", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the selected buttons low long enough to be accepted, then release
  // and wait for the release to settle.
  task automatic press(input bit run, input bit stp);
    $display("press run=%0b step=%0b count=%0d t=%0t", run, stp, bus.cycle_count, $time);
    if (run) bus.btn_run_n = 1'b0;
    if (stp) bus.btn_step_n = 1'b0;
    step(10);
    bus.btn_run_n  = 1'b1;
    bus.btn_step_n = 1'b1;
    step(10);
  endtask

  // Every complete cpu_clk high pulse must last exactly one half-period.
  always @(negedge clk) begin
    if (reset) begin
      hi_len = 0;
    end else if (bus.cpu_clk === 1'b1) begin
      hi_len++;
    end else if (hi_len != 0) begin
      checks++;
      pulses++;
      assert (hi_len == HALF) else begin
        failures++;
        $error("FAIL pulse_width observed=%0d expected=%0d", hi_len, HALF);
      end
      hi_len = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL tb_timeout simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "tb timeout");
  end

  initial begin
    int          n;
    int          p0;
    logic [63:0] c0;

    reset          = 1'b1;
    bus.btn_run_n  = 1'b1;
    bus.btn_step_n = 1'b1;
    bus.done       = 1'b0;

    // Reset values
    expect_v("rst_cpu_clk", 0);
    expect_v("rst_cpu_reset", 1);
    expect_v("rst_cycle_count", 0);
    expect_v("rst_running", 0);
    expect_v("rst_halted", 0);
    expect_v("rst_led_n", 1);
    expect_v("rst_timeout", 0);
    step(3);
    check_v(bus.cpu_clk);
    check_v(bus.cpu_reset);
    check_v(bus.cycle_count);
    check_v(bus.running);
    check_v(bus.halted);
    check_v(bus.led_n);
    check_v(bus.timeout);
    reset = 1'b0;

    // Idle with no buttons: stays in reset, no clock
    expect_v("idle_cpu_reset", 1);
    expect_v("idle_cpu_clk", 0);
    expect_v("idle_running", 0);
    expect_v("idle_halted", 0);
    expect_v("idle_pulses", 0);
    step(50);
    check_v(bus.cpu_reset);
    check_v(bus.cpu_clk);
    check_v(bus.running);
    check_v(bus.halted);
    check_v(pulses);

    // A 2-clk bounce is not a press
    expect_v("bounce_cpu_reset", 1);
    bus.btn_run_n = 1'b0;
    step(2);
    bus.btn_run_n = 1'b1;
    step(30);
    check_v(bus.cpu_reset);

    // Run press: CLEAR then PAUSE with reset released
    expect_v("pause_cpu_reset", 0);
    expect_v("pause_cycle_count", 0);
    expect_v("pause_running", 0);
    expect_v("pause_cpu_clk", 0);
    press(1'b1, 1'b0);
    n = 0;
    while (bus.cpu_reset !== 1'b0 && n < 40) begin step(1); n++; end
    check_v(bus.cpu_reset);
    check_v(bus.cycle_count);
    check_v(bus.running);
    check_v(bus.cpu_clk);

    // done rising while paused must not halt
    expect_v("pause_done_halted", 0);
    expect_v("pause_done_running", 0);
    bus.done = 1'b1;
    step(30);
    check_v(bus.halted);
    check_v(bus.running);
    bus.done = 1'b0;
    step(5);

    // Three single steps
    p0 = pulses;
    expect_v("step_pulses", p0 + 3);
    expect_v("step_cycle_count", 3);
    expect_v("step_running", 0);
    expect_v("step_halted", 0);
    expect_v("step_cpu_clk", 0);
    expect_v("step_cpu_reset", 0);
    repeat (3) press(1'b0, 1'b1);
    step(10);
    check_v(pulses);
    check_v(bus.cycle_count);
    check_v(bus.running);
    check_v(bus.halted);
    check_v(bus.cpu_clk);
    check_v(bus.cpu_reset);

    // RUN; done raised at cycle_count=7 halts only after cpu_clk falls
    expect_v("done_reach_7", 7);
    expect_v("done_clk_high_at_7", 1);
    expect_v("done_not_halted_yet", 0);
    press(1'b1, 1'b0);
    n = 0;
    while (bus.cycle_count !== 7 && n < 100) begin step(1); n++; end
    check_v(bus.cycle_count);
    check_v(bus.cpu_clk);
    check_v(bus.halted);
    bus.done = 1'b1;
    expect_v("halt_halted", 1);
    expect_v("halt_cycle_count", 7);
    expect_v("halt_cpu_clk", 0);
    expect_v("halt_running", 0);
    expect_v("halt_timeout", 0);
    n = 0;
    while (bus.halted !== 1'b1 && n < 30) begin step(1); n++; end
    check_v(bus.halted);
    check_v(bus.cycle_count);
    check_v(bus.cpu_clk);
    check_v(bus.running);
    check_v(bus.timeout);
    bus.done = 1'b0;

    // Step is ignored in HALT
    expect_v("halt_step_halted", 1);
    expect_v("halt_step_count", 7);
    press(1'b0, 1'b1);
    step(10);
    check_v(bus.halted);
    check_v(bus.cycle_count);

    // Run from HALT restarts through processor reset
    expect_v("restart_cpu_reset", 1);
    expect_v("restart_cycle_count", 0);
    expect_v("restart_halted", 0);
    bus.btn_run_n = 1'b0;
    n = 0;
    while (bus.halted !== 1'b0 && n < 20) begin step(1); n++; end
    check_v(bus.cpu_reset);
    check_v(bus.cycle_count);
    check_v(bus.halted);
    step(10);
    bus.btn_run_n = 1'b1;
    step(10);
    expect_v("restart_pause_cpu_reset", 0);
    n = 0;
    while (bus.cpu_reset !== 1'b0 && n < 20) begin step(1); n++; end
    check_v(bus.cpu_reset);

    // Free-run period: 5 rising edges in any 40-clk window
    expect_v("run_running", 1);
    press(1'b1, 1'b0);
    n = 0;
    while (bus.running !== 1'b1 && n < 20) begin step(1); n++; end
    check_v(bus.running);
    c0 = bus.cycle_count;
    expect_v("run_40clk_count", c0 + 5);
    step(40);
    check_v(bus.cycle_count);
    expect_v("run_led_when_high", 0);
    n = 0;
    while (bus.cpu_clk !== 1'b1 && n < 10) begin step(1); n++; end
    check_v(bus.led_n);
    expect_v("run_led_when_low", 1);
    n = 0;
    while (bus.cpu_clk !== 1'b0 && n < 10) begin step(1); n++; end
    check_v(bus.led_n);

    // Step press in RUN is latched and pauses at the end of the period
    expect_v("pend_running", 0);
    expect_v("pend_cpu_clk", 0);
    press(1'b0, 1'b1);
    check_v(bus.running);
    check_v(bus.cpu_clk);
    c0 = bus.cycle_count;
    expect_v("pend_count_stable", c0);
    step(30);
    check_v(bus.cycle_count);

    // Run and step together from PAUSE: run wins
    expect_v("both_running", 1);
    expect_v("both_still_running", 1);
    press(1'b1, 1'b1);
    n = 0;
    while (bus.running !== 1'b1 && n < 20) begin step(1); n++; end
    check_v(bus.running);
    step(30);
    check_v(bus.running);

    // Asynchronous reset with cpu_clk high
    expect_v("areset_pre_clk_high", 1);
    n = 0;
    while (bus.cpu_clk !== 1'b1 && n < 20) begin step(1); n++; end
    check_v(bus.cpu_clk);
    expect_v("areset_cpu_clk", 0);
    expect_v("areset_cpu_reset", 1);
    expect_v("areset_cycle_count", 0);
    expect_v("areset_running", 0);
    expect_v("areset_halted", 0);
    expect_v("areset_led_n", 1);
    expect_v("areset_timeout", 0);
    #2;
    reset = 1'b1;
    #1;
    check_v(bus.cpu_clk);
    check_v(bus.cpu_reset);
    check_v(bus.cycle_count);
    check_v(bus.running);
    check_v(bus.halted);
    check_v(bus.led_n);
    check_v(bus.timeout);
    step(3);
    reset = 1'b0;
    step(2);

`ifdef CPU_CLK_WATCHDOG_EN
    // Watchdog: done held low in RUN
    expect_v("wd_halted", 1);
    expect_v("wd_timeout", 1);
    expect_v("wd_cycle_count", TB_MAX);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    n = 0;
    while (bus.halted !== 1'b1 && n < (TB_MAX * 2 * HALF + 200)) begin step(1); n++; end
    check_v(bus.halted);
    check_v(bus.timeout);
    check_v(bus.cycle_count);
    expect_v("wd_clear_timeout", 0);
    bus.btn_run_n = 1'b0;
    n = 0;
    while (bus.halted !== 1'b0 && n < 20) begin step(1); n++; end
    step(1);
    check_v(bus.timeout);
    step(10);
    bus.btn_run_n = 1'b1;
    step(10);
`endif

    checks++;
    assert (sb_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
